// File: rtl/rvm_shift_unit_pkg.sv
// Shared encodings for the iterative shift unit: operation codes, FSM
// state encodings, datapath widths and a step-size legality helper.
package rvm_shift_unit_pkg;

  // Datapath width and width of the shift-amount field.
  localparam int SHF_WIDTH = 32;
  localparam int SHF_AMT_W = 5;

  // Operation encodings as presented by the control FSM.
  typedef enum logic [1:0] {
    RVM_SHIFT_SLL = 2'b00,
    RVM_SHIFT_SRL = 2'b01,
    RVM_SHIFT_SRA = 2'b10,
    RVM_SHIFT_RSV = 2'b11
  } shf_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    RVM_SHF_IDLE = 2'b00,
    RVM_SHF_BUSY = 2'b01,
    RVM_SHF_DONE = 2'b10
  } shf_state_e;

  // Only powers of two up to the full word width are supported per-cycle steps.
  function automatic bit shf_step_legal(input int step);
    return (step == 1) || (step == 2) || (step == 4) ||
           (step == 8) || (step == 16) || (step == 32);
  endfunction

endpackage

// File: rtl/rvm_shift_step.sv
// Combinational single-step barrel shifter. Shifts acc by 'step' positions
// (step never exceeds MAX_STEP) using only the binary stages that MAX_STEP
// can actually reach; the unreachable stages fold away as constants.
module rvm_shift_step
  import rvm_shift_unit_pkg::*;
#(
  parameter int MAX_STEP = 1
) (
  input  logic [31:0] acc,
  input  logic [4:0]  step,
  input  logic [1:0]  op,
  input  logic        sign,
  output logic [31:0] result
);

  localparam logic [31:0] ONES = '1;

  logic        left;
  logic        fill;
  logic [31:0] shifted;

  // Left shifts zero-fill; right shifts fill with the latched sign only for SRA.
  assign left = (op == RVM_SHIFT_SLL);
  assign fill = (op == RVM_SHIFT_SRA) && sign;

  // Log-stage barrel: stage i shifts by 2**i when step[i] is set and the
  // stage is reachable for this MAX_STEP.
  always_comb begin
    shifted = acc;
    for (int i = 0; i < SHF_AMT_W; i++) begin
      if (((1 << i) <= MAX_STEP) && step[i]) begin
        if (left) begin
          shifted = shifted << (1 << i);
        end else begin
          shifted = (shifted >> (1 << i)) | (fill ? ~(ONES >> (1 << i)) : '0);
        end
      end
    end
  end

  assign result = shifted;

endmodule

// File: rtl/rvm_shift_unit.sv
// Iterative multi-cycle shift unit (SLL/SRL/SRA). Latches operands on an
// accepted request, then shifts the accumulator by at most SHF_STEP bits per
// busy cycle, and pulses shf_valid for one cycle when the result is complete.
module rvm_shift_unit
  import rvm_shift_unit_pkg::*;
#(
  parameter int SHF_STEP = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        shf_req,
  input  logic [31:0] shf_lhs,
  input  logic [31:0] shf_rhs,
  input  logic [1:0]  shf_op,
  output logic        shf_busy,
  output logic        shf_valid,
  output logic [31:0] shf_result
);

  // Refuse to elaborate with a step size the barrel is not built for.
  if (!shf_step_legal(SHF_STEP)) begin : g_bad_step
    $error("rvm_shift_unit: SHF_STEP must be 1, 2, 4, 8, 16 or 32");
  end

  localparam logic [5:0] STEP_MAX = 6'(SHF_STEP);

  shf_state_e  state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [4:0]  rem_reg, rem_next;
  logic        sign_reg, sign_next;
  logic [1:0]  op_reg, op_next;

  logic [4:0]  step;
  logic [31:0] step_acc;
  logic        unused_rhs;

  // Only the low five amount bits matter; larger amounts wrap modulo 32.
  assign unused_rhs = ^shf_rhs[31:5];

  // Bits consumed this cycle: the remaining count, capped at SHF_STEP.
  // rem_reg never exceeds 31, so the cap branch is never taken when SHF_STEP is 32.
  assign step = ({1'b0, rem_reg} > STEP_MAX) ? STEP_MAX[4:0] : rem_reg;

  rvm_shift_step #(
    .MAX_STEP (SHF_STEP)
  ) u_step (
    .acc    (acc_reg),
    .step   (step),
    .op     (op_reg),
    .sign   (sign_reg),
    .result (step_acc)
  );

  // Next-state and datapath-update logic; holds everything by default.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    sign_next  = sign_reg;
    op_next    = op_reg;
    case (state_reg)
      RVM_SHF_IDLE, RVM_SHF_DONE: begin
        if (shf_req) begin
          acc_next  = shf_lhs;
          rem_next  = shf_rhs[4:0];
          sign_next = shf_lhs[31];
          op_next   = shf_op;
          // Nothing to shift: result is ready in the very next cycle.
          if ((shf_rhs[4:0] == 5'd0) || (shf_op == RVM_SHIFT_RSV)) begin
            state_next = RVM_SHF_DONE;
          end else begin
            state_next = RVM_SHF_BUSY;
          end
        end else begin
          state_next = RVM_SHF_IDLE;
        end
      end
      RVM_SHF_BUSY: begin
        // Inputs are deliberately not looked at here.
        acc_next = step_acc;
        rem_next = rem_reg - step;
        if (rem_reg == step) begin
          state_next = RVM_SHF_DONE;
        end
      end
      default: begin
        state_next = RVM_SHF_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset; a reset
  // mid-operation drops the in-flight shift without a valid pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= RVM_SHF_IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      sign_reg  <= 1'b0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      sign_reg  <= sign_next;
      op_reg    <= op_next;
    end
  end

  assign shf_busy   = (state_reg == RVM_SHF_BUSY);
  assign shf_valid  = (state_reg == RVM_SHF_DONE);
  assign shf_result = acc_reg;

endmodule

// File: tb/tb_rvm_shift_unit.sv
// Self-checking bench for rvm_shift_unit. Two instances (SHF_STEP=1 and
// SHF_STEP=4) share the same stimulus; each is checked against an
// arithmetic reference for result, latency, busy-cycle count and pulse count.
module tb_rvm_shift_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        shf_req = 1'b0;
  logic [31:0] shf_lhs = '0;
  logic [31:0] shf_rhs = '0;
  logic [1:0]  shf_op = '0;

  logic        busy1, valid1, busy4, valid4;
  logic [31:0] result1, result4;

  int n_cmp = 0;
  int n_bad = 0;

  int          first_valid [2];
  int          vcount [2];
  int          bcount [2];
  logic [31:0] res_valid [2];

  always #5 clk = ~clk;

  rvm_shift_unit #(.SHF_STEP(1)) u_dut1 (
    .clk        (clk),
    .resetn     (resetn),
    .shf_req    (shf_req),
    .shf_lhs    (shf_lhs),
    .shf_rhs    (shf_rhs),
    .shf_op     (shf_op),
    .shf_busy   (busy1),
    .shf_valid  (valid1),
    .shf_result (result1)
  );

  rvm_shift_unit #(.SHF_STEP(4)) u_dut4 (
    .clk        (clk),
    .resetn     (resetn),
    .shf_req    (shf_req),
    .shf_lhs    (shf_lhs),
    .shf_rhs    (shf_rhs),
    .shf_op     (shf_op),
    .shf_busy   (busy4),
    .shf_valid  (valid4),
    .shf_result (result4)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from the ISA definition of each shift.
  function automatic logic [31:0] ref_result(input logic [31:0] lhs, input logic [31:0] rhs,
                                             input logic [1:0] op);
    int amt;
    amt = int'(rhs[4:0]);
    case (op)
      2'd0:    return lhs << amt;
      2'd1:    return lhs >> amt;
      2'd2:    return $signed(lhs) >>> amt;
      default: return lhs;
    endcase
  endfunction

  // Accept-to-valid distance: one cycle plus ceil(amount / step).
  function automatic int ref_latency(input logic [31:0] rhs, input logic [1:0] op, input int step);
    int amt;
    amt = int'(rhs[4:0]);
    if (op == 2'd3 || amt == 0) return 1;
    return 1 + (amt + step - 1) / step;
  endfunction

  task automatic clear_track();
    for (int d = 0; d < 2; d++) begin
      first_valid[d] = -1;
      vcount[d]      = 0;
      bcount[d]      = 0;
      res_valid[d]   = '0;
    end
  endtask

  // Record observations for cycle k after the accept edge.
  task automatic sample(input int k);
    if (valid1) begin
      if (first_valid[0] < 0) begin
        first_valid[0] = k;
        res_valid[0]   = result1;
      end
      vcount[0]++;
    end
    if (busy1) bcount[0]++;
    if (valid4) begin
      if (first_valid[1] < 0) begin
        first_valid[1] = k;
        res_valid[1]   = result4;
      end
      vcount[1]++;
    end
    if (busy4) bcount[1]++;
  endtask

  task automatic check_txn(input string tag, input logic [31:0] lhs, input logic [31:0] rhs,
                           input logic [1:0] op);
    logic [31:0] exp_res;
    int          exp_lat;
    int          step;
    logic [31:0] now_res;
    exp_res = ref_result(lhs, rhs, op);
    for (int d = 0; d < 2; d++) begin
      step    = (d == 0) ? 1 : 4;
      now_res = (d == 0) ? result1 : result4;
      exp_lat = ref_latency(rhs, op, step);
      check_value($sformatf("%s s%0d latency", tag, step), 32'(first_valid[d]), 32'(exp_lat));
      check_value($sformatf("%s s%0d pulses", tag, step), 32'(vcount[d]), 32'd1);
      check_value($sformatf("%s s%0d busy_cycles", tag, step), 32'(bcount[d]), 32'(exp_lat - 1));
      check_value($sformatf("%s s%0d result", tag, step), res_valid[d], exp_res);
      check_value($sformatf("%s s%0d held", tag, step), now_res, exp_res);
    end
    $display("txn %-10s lhs=%h rhs=%h op=%0d exp=%h lat1=%0d lat4=%0d", tag, lhs, rhs, op,
             exp_res, first_valid[0], first_valid[1]);
  endtask

  // Issue one request at the current negedge and watch a fixed window.
  // With perturb set, operands churn every cycle and req is pulsed while busy.
  task automatic run_op(input string tag, input logic [31:0] lhs, input logic [31:0] rhs,
                        input logic [1:0] op, input bit perturb);
    shf_lhs = lhs;
    shf_rhs = rhs;
    shf_op  = op;
    shf_req = 1'b1;
    clear_track();
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      sample(k);
      shf_req = 1'b0;
      if (perturb) begin
        shf_lhs = $urandom;
        shf_rhs = $urandom;
        shf_op  = 2'($urandom_range(0, 3));
        shf_req = busy1 && busy4 && ($urandom_range(0, 1) == 1);
      end
    end
    check_txn(tag, lhs, rhs, op);
  endtask

  initial begin
    logic [31:0] r_lhs, r_rhs;
    logic [1:0]  r_op;
    bit          r_pert;

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset busy1", 32'(busy1), 32'd0);
    check_value("reset valid1", 32'(valid1), 32'd0);
    check_value("reset result1", result1, 32'h0);
    check_value("reset busy4", 32'(busy4), 32'd0);
    check_value("reset valid4", 32'(valid4), 32'd0);
    check_value("reset result4", result4, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op("sll31", 32'h0000_0001, 32'd31, 2'd0, 1'b0);
    check_value("sll31 const", res_valid[0], 32'h8000_0000);
    run_op("sra4", 32'h8000_00F0, 32'd4, 2'd2, 1'b0);
    check_value("sra4 const", res_valid[0], 32'hF800_000F);
    run_op("srl4", 32'h8000_00F0, 32'd4, 2'd1, 1'b0);
    check_value("srl4 const", res_valid[0], 32'h0800_000F);
    run_op("amt32", 32'hDEAD_BEEF, 32'h0000_0020, 2'd0, 1'b0);
    run_op("rsv", 32'hDEAD_BEEF, 32'd7, 2'd3, 1'b0);
    run_op("srl31p", 32'hFFFF_FFFF, 32'd31, 2'd1, 1'b1);
    check_value("srl31p const", res_valid[1], 32'h0000_0001);

    // Reset in the middle of a shift.
    shf_lhs = $urandom;
    shf_rhs = 32'd20;
    shf_op  = 2'd0;
    shf_req = 1'b1;
    clear_track();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      sample(k);
      shf_req = 1'b0;
    end
    check_value("midrst busy1 before", 32'(busy1), 32'd1);
    check_value("midrst busy4 before", 32'(busy4), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_value("midrst busy1", 32'(busy1), 32'd0);
    check_value("midrst valid1", 32'(valid1), 32'd0);
    check_value("midrst result1", result1, 32'h0);
    check_value("midrst busy4", 32'(busy4), 32'd0);
    check_value("midrst valid4", 32'(valid4), 32'd0);
    check_value("midrst result4", result4, 32'h0);
    resetn = 1'b1;
    clear_track();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sample(k);
    end
    check_value("midrst no_pulse1", 32'(vcount[0]), 32'd0);
    check_value("midrst no_pulse4", 32'(vcount[1]), 32'd0);
    $display("txn midrst     reset during SLL by 20, no pulse afterwards");
    run_op("post_rst", 32'd1, 32'd1, 2'd0, 1'b0);

    // Back-to-back: request held through BUSY (ignored) and into DONE (accepted).
    shf_lhs = 32'd5;
    shf_rhs = 32'd1;
    shf_op  = 2'd0;
    shf_req = 1'b1;
    @(negedge clk);
    shf_lhs = 32'hFFFF_0000;
    shf_rhs = 32'd7;
    shf_op  = 2'd2;
    @(negedge clk);
    check_value("b2b1 valid1", 32'(valid1), 32'd1);
    check_value("b2b1 valid4", 32'(valid4), 32'd1);
    check_value("b2b1 result1", result1, 32'd10);
    check_value("b2b1 result4", result4, 32'd10);
    $display("txn b2b1       lhs=5 rhs=1 SLL with req held through busy");
    run_op("b2b2", 32'd3, 32'd2, 2'd0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      r_lhs  = $urandom;
      r_rhs  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      r_op   = 2'($urandom_range(0, 3));
      r_pert = ($urandom_range(0, 1) == 1);
      run_op($sformatf("rnd%0d", t), r_lhs, r_rhs, r_op, r_pert);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
